spi_tx_arbiter: RTL and testbench
=================================

# spi_tx_arbiter

Round-robin arbiter and frame sequencer that shares one 16-bit SPI transmit engine (`spi_design` class: CS/SCLK/data shifter) between up to NREQ requesters. It latches the winning requester's word, pulses a start to the engine, waits for frame completion with a watchdog, acknowledges the requester, and enforces an inter-frame gap. It sits between requesting blocks and the SPI engine.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 16, frame data width
- GAP, 2, idle cycles after each frame (legal 1..15)
- TIMEOUT, 64, max WAIT cycles before abort (legal 4..255)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level; held until its ack
- req_data  in  NREQ*DW  requester i word at [i*DW +: DW]; stable while req[i] high
- ack  out  NREQ  one-cycle pulse to the served requester at frame end/abort
- err  out  1  one-cycle pulse, coincident with ack, on timeout abort
- tx_start  out  1  one-cycle start pulse to SPI engine
- tx_data  out  DW  word to transmit; stable from tx_start until ack
- tx_sel  out  $clog2(NREQ)  index of granted requester (drives CS select)
- tx_done  in  1  one-cycle pulse from engine at end of frame
- busy  out  1  high whenever state != IDLE
- frame_cnt  out  16  successful frames completed; wraps FFFF->0000

## Operation
- States: IDLE, START, WAIT, GAP. All outputs registered or decoded from state only.
- IDLE: if any req bit high, select first set bit scanning (last+1) mod NREQ upward with wrap; latch tx_data <= req_data slice, tx_sel <= index; go START. No req: stay.
- START: tx_start=1 for exactly this cycle; clear timer; go WAIT.
- WAIT: timer increments each cycle. tx_done=1 -> ack[tx_sel]=1 next cycle, frame_cnt+1, last <= tx_sel, go GAP. Timer==TIMEOUT-1 and tx_done=0 -> ack[tx_sel]=1 and err=1 next cycle, frame_cnt unchanged, last <= tx_sel, go GAP.
- GAP: ack/err high in first GAP cycle only; stay GAP cycles total, then IDLE.
- tx_done outside WAIT ignored. req changes outside IDLE ignored.
- Requester rule: drop req[i] no later than the cycle after its ack; arbiter next samples req at earliest that cycle (GAP>=1).
- Reset: state IDLE, last=NREQ-1 (req0 highest priority first), ack=0, err=0, tx_start=0, tx_data=0, tx_sel=0, busy=0, frame_cnt=0, timer=0. A frame in progress is abandoned with no ack.

## Timing
- Cycle 0 IDLE samples req -> cycle 1 tx_start=1, tx_data/tx_sel valid -> cycle 2 first WAIT cycle.
- tx_done sampled in cycle D -> ack at D+1 -> IDLE at D+GAP+1 -> next tx_start at D+GAP+2 earliest.
- Timeout: WAIT entered cycle 2, abort detected cycle TIMEOUT+1, ack+err at TIMEOUT+2.
- tx_done in same cycle timer hits TIMEOUT-1: success, err=0.
- Back-to-back throughput: one frame per (engine frame length + GAP + 2) cycles.
- busy high from cycle 1 through last GAP cycle.

## Test plan
- Reset, req=0001, req_data0=A569, tx_done 32 cycles after tx_start -> tx_start at cycle 1, tx_data=A569, tx_sel=0, ack=0001 single cycle at D+1, err=0, frame_cnt=1, busy low at D+GAP+1.
- req=1111, data 0..3 = A569/2563/9B63/6A61, each dropped after ack -> frames in order sel 0,1,2,3 with matching tx_data, GAP idle cycles between, frame_cnt=4.
- req0 and req2 re-raised immediately after each ack, 6 frames -> sel sequence 0,2,0,2,0,2; req1/req3 never acked.
- req=0010, tx_done never asserted, TIMEOUT=64 -> ack=0010 and err=1 at cycle 66, frame_cnt stays 0; then req=0101 -> sel 2 served first.
- Reset asserted mid-WAIT with req=1000 -> all outputs zero next cycle, no ack; after release with req=1000 held -> sel 3 served, ack once, frame_cnt=1.
- tx_done pulsed in IDLE and GAP -> no state change, no ack; tx_done exactly at timer TIMEOUT-1 -> ack with err=0, frame_cnt increments.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter and frame sequencer sharing one SPI transmit engine
// between NREQ requesters, with a completion watchdog and an inter-frame gap.
module spi_tx_arbiter #(
    parameter int  NREQ    = 4,
    parameter int  DW      = 16,
    parameter int  GAP     = 2,
    parameter int  TIMEOUT = 64,
    localparam int SW      = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic               tx_start,
    output logic [DW-1:0]      tx_data,
    output logic [SW-1:0]      tx_sel,
    input  logic               tx_done,
    output logic               busy,
    output logic [15:0]        frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    state_t         state;
    state_t         state_nxt;
    logic [SW-1:0]  last;
    logic [7:0]     timer;
    logic [3:0]     gap_cnt;
    logic           grant_valid;
    logic [SW-1:0]  grant_idx;
    logic [SW-1:0]  cand;
    logic           wait_end;

    // Round-robin pick: first set request strictly after the last served index.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = SW'((int'(last) + i) % NREQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign wait_end = tx_done || (timer == TMO_LAST);

    always_comb begin
        state_nxt = state;
        tx_start  = (state == S_START);
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:  if (grant_valid) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (wait_end) state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so all state advances together.
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= SW'(NREQ - 1);
            timer     <= '0;
            gap_cnt   <= '0;
            ack       <= '0;
            err       <= 1'b0;
            tx_data   <= '0;
            tx_sel    <= '0;
            frame_cnt <= '0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        tx_data <= req_data[int'(grant_idx)*DW +: DW];
                        tx_sel  <= grant_idx;
                    end
                end
                S_START: timer <= '0;
                S_WAIT: begin
                    timer <= timer + 8'd1;
                    if (wait_end) begin
                        // A completion in the watchdog's last cycle still counts as success.
                        ack     <= NREQ'(1) << tx_sel;
                        err     <= !tx_done;
                        last    <= tx_sel;
                        gap_cnt <= '0;
                        if (tx_done) frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                S_GAP: gap_cnt <= gap_cnt + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: engine and requester models plus a
// scoreboard of expected frames checked at tx_start and at ack.
module tb_spi_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 16;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 64;
    localparam int SW      = $clog2(NREQ);

    typedef struct {
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic               tx_start;
    logic [DW-1:0]      tx_data;
    logic [SW-1:0]      tx_sel;
    logic               tx_done;
    logic               busy;
    logic [15:0]        frame_cnt;

    spi_tx_arbiter #(.NREQ(NREQ), .DW(DW), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .err(err), .tx_start(tx_start), .tx_data(tx_data),
        .tx_sel(tx_sel), .tx_done(tx_done), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]   words [NREQ] = '{16'hA569, 16'h2563, 16'h9B63, 16'h6A61};
    exp_t            sb_q [$];
    exp_t            cur;
    int              n_vec = 0;
    int              n_err = 0;
    int              cyc = 0;
    int              eng_len = 0;
    int              eng_cnt = 0;
    int              last_start = 0;
    int              last_ack = 0;
    int              ack_total = 0;
    int              exp_fc = 0;
    int              ack_cnt [NREQ];
    logic            in_frame = 1'b0;
    logic [NREQ-1:0] reraise = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input int sel, input logic e);
        exp_t x;
        x.sel  = SW'(sel);
        x.data = words[sel];
        x.err  = e;
        sb_q.push_back(x);
    endtask

    // One clock: observe the cycle just entered, then drive engine/requester inputs for it.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (!reset) begin
            if (tx_start) begin
                chk("start_outside_frame", 32'(in_frame), 0);
                chk("start_expected", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    cur = sb_q[0];
                    chk("tx_sel", 32'(tx_sel), 32'(cur.sel));
                    chk("tx_data", 32'(tx_data), 32'(cur.data));
                end
                in_frame   = 1'b1;
                last_start = cyc;
                eng_cnt    = eng_len;
            end
            if (ack != '0) begin
                chk("ack_in_frame", 32'(in_frame), 1);
                if (sb_q.size() != 0) begin
                    cur = sb_q.pop_front();
                    if (!cur.err) exp_fc++;
                    chk("ack", 32'(ack), 32'(NREQ'(1) << cur.sel));
                    chk("err", 32'(err), 32'(cur.err));
                    chk("frame_cnt", 32'(frame_cnt), exp_fc);
                end
                for (int i = 0; i < NREQ; i++) if (ack[i]) ack_cnt[i]++;
                in_frame  = 1'b0;
                last_ack  = cyc;
                ack_total++;
                req = req & ~(ack & ~reraise);
            end else if (err) begin
                chk("err_without_ack", 32'(err), 0);
            end
        end
        tx_done = 1'b0;
        if (reset) eng_cnt = 0;
        else if (!tx_start && eng_cnt != 0) begin
            eng_cnt--;
            tx_done = (eng_cnt == 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_acks(input int n, input int budget);
        int target;
        target = ack_total + n;
        for (int i = 0; i < budget && ack_total < target; i++) cycle();
        chk("ack_within_budget", 32'(ack_total >= target), 1);
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget && !in_frame; i++) cycle();
        chk("start_within_budget", 32'(in_frame), 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_tx_start"}, 32'(tx_start), 0);
        chk({tag, "_tx_data"}, 32'(tx_data), 0);
        chk({tag, "_tx_sel"}, 32'(tx_sel), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    task automatic reset_dut();
        reset   = 1'b1;
        req     = '0;
        reraise = '0;
        eng_len = 0;
        idle(2);
        check_zero("reset");
        sb_q.delete();
        in_frame = 1'b0;
        exp_fc   = 0;
        for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        int prev_ack;
        reset   = 1'b1;
        req     = '0;
        tx_done = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = words[i];

        // Single requester, 32-cycle engine frame.
        reset_dut();
        idle(2);
        chk("idle_busy", 32'(busy), 0);
        req = 4'b0001;
        expect_frame(0, 1'b0);
        eng_len = 32;
        c0 = cyc;
        wait_acks(1, 200);
        chk("start_latency", last_start - c0, 1);
        chk("ack_latency", last_ack - last_start, 33);
        cycle();
        chk("busy_in_gap", 32'(busy), 1);
        cycle();
        chk("busy_after_gap", 32'(busy), 0);
        idle(3);

        // All four requesting, each dropped after its ack.
        reset_dut();
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) expect_frame(i, 1'b0);
        eng_len = 8;
        for (int k = 0; k < NREQ; k++) begin
            prev_ack = last_ack;
            wait_acks(1, 100);
            if (k > 0) chk("b2b_gap", last_start - prev_ack, GAP + 1);
        end
        idle(6);
        chk("rr_frame_cnt", 32'(frame_cnt), 4);
        chk("rr_drained", 32'(sb_q.size()), 0);

        // req0 and req2 re-raised after every ack: strict alternation.
        reset_dut();
        reraise = 4'b0101;
        req     = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            expect_frame(0, 1'b0);
            expect_frame(2, 1'b0);
        end
        eng_len = 5;
        wait_acks(4, 200);
        reraise = '0;
        wait_acks(2, 100);
        idle(8);
        chk("alt_ack1", ack_cnt[1], 0);
        chk("alt_ack3", ack_cnt[3], 0);
        chk("alt_frame_cnt", 32'(frame_cnt), 6);

        // Engine never completes: watchdog abort, then round-robin resumes after sel 1.
        reset_dut();
        req = 4'b0010;
        expect_frame(1, 1'b1);
        eng_len = 0;
        wait_acks(1, TIMEOUT + 20);
        chk("timeout_latency", last_ack - last_start, TIMEOUT + 1);
        chk("timeout_frame_cnt", 32'(frame_cnt), 0);
        req = 4'b0101;
        expect_frame(2, 1'b0);
        expect_frame(0, 1'b0);
        eng_len = 6;
        wait_acks(2, 100);
        idle(4);
        chk("after_timeout_frame_cnt", 32'(frame_cnt), 2);

        // Reset in the middle of WAIT abandons the frame without an ack.
        reset_dut();
        req = 4'b1000;
        expect_frame(3, 1'b0);
        eng_len = 0;
        wait_start(20);
        idle(5);
        reset = 1'b1;
        cycle();
        check_zero("midwait");
        sb_q.delete();
        in_frame = 1'b0;
        reset    = 1'b0;
        expect_frame(3, 1'b0);
        eng_len = 10;
        wait_acks(1, 100);
        idle(6);
        chk("midwait_ack3_once", ack_cnt[3], 1);
        chk("midwait_frame_cnt", 32'(frame_cnt), 1);

        // Stray tx_done in IDLE/GAP; completion exactly on the watchdog's last cycle.
        reset_dut();
        idle(1);
        tx_done = 1'b1;
        cycle();
        chk("idle_done_busy", 32'(busy), 0);
        chk("idle_done_frame_cnt", 32'(frame_cnt), 0);
        req = 4'b0001;
        expect_frame(0, 1'b0);
        eng_len = TIMEOUT;
        wait_acks(1, TIMEOUT + 20);
        chk("edge_done_latency", last_ack - last_start, TIMEOUT + 1);
        tx_done = 1'b1;
        cycle();
        chk("gap_done_busy", 32'(busy), 1);
        cycle();
        chk("gap_done_idle", 32'(busy), 0);
        idle(4);
        chk("edge_frame_cnt", 32'(frame_cnt), 1);
        chk("final_drained", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
